pll_lock_sequencer: RTL and testbench

- Controls the iCE40 SB_PLL40_CORE from the reference (crystal) clock domain.
- Drives PLL RESETB, waits for LOCK with a timeout and bounded retries, and requires LOCK to stay stable before releasing the core reset.
- Detects lock loss at runtime and re-runs the sequence.
- Replaces the free-running 4-bit startup counter as the source of the design-wide reset.

---
 rtl/pll_seq_pkg.sv | 30 +++
 rtl/pll_lock_sequencer_lock_sync.sv | 48 ++++
 rtl/pll_lock_sequencer.sv | 125 ++++++++++++
 tb/tb_pll_lock_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared state encoding, default timing constants and timer sizing for the
// PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'b000,
    WAIT_LOCK = 3'b001,
    STABLE    = 3'b010,
    RUN       = 3'b011,
    FAULT     = 3'b100
  } pll_state_t;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 4096;
  localparam int unsigned DEF_STABLE_CYCLES = 256;
  localparam int unsigned DEF_MAX_RETRIES   = 3;
  localparam int unsigned DEF_LOSS_W        = 8;
  localparam int unsigned DEF_GLITCH_CYCLES = 4;

  // The timer only ever counts up to (period - 1), so clog2 of the largest period suffices.
  function automatic int unsigned timer_w(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? int'($clog2(m)) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL LOCK, plus the lock-low filter.
// Filter is active only when LOCK_GLITCH_FILTER_EN is defined.
module lock_sync #(
  parameter int unsigned GLITCH_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  output logic lock_s,
  output logic lock_lost
);

`ifdef LOCK_GLITCH_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  localparam int unsigned GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam logic [GW-1:0] LOW_LAST = GW'((GLITCH_CYCLES > 0) ? GLITCH_CYCLES - 1 : 0);

  logic          r_meta;
  logic          r_sync;
  logic [GW-1:0] r_low_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= pll_lock;
      r_sync <= r_meta;
    end
  end

  // Counts consecutive low cycles of the synchronized lock; saturates at the filter length.
  always_ff @(posedge clk) begin
    if (rst || r_sync) begin
      r_low_cnt <= '0;
    end else if (r_low_cnt != LOW_LAST) begin
      r_low_cnt <= r_low_cnt + 1'b1;
    end
  end

  assign lock_s    = r_sync;
  assign lock_lost = FILTER_ON ? (~r_sync & (r_low_cnt == LOW_LAST)) : ~r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL RESETB / lock-wait / stability sequencer producing the design-wide core reset.
// Optional lock-loss glitch filter: define LOCK_GLITCH_FILTER_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int unsigned LOSS_W        = DEF_LOSS_W,
  parameter int unsigned GLITCH_CYCLES = DEF_GLITCH_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_lock,
  input  logic              restart,
  output logic              pll_resetb,
  output logic              core_rst,
  output logic              ready,
  output logic              fault,
  output logic [1:0]        retry_cnt,
  output logic [LOSS_W-1:0] loss_cnt,
  output logic [2:0]        state
);

  localparam int unsigned TW = timer_w(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

  pll_state_t        r_state;
  pll_state_t        w_next_state;
  logic [TW-1:0]     r_timer;
  logic [1:0]        r_retry_cnt;
  logic [LOSS_W-1:0] r_loss_cnt;
  logic              w_lock_s;
  logic              w_lock_lost;

  lock_sync #(
    .GLITCH_CYCLES(GLITCH_CYCLES)
  ) u_lock_sync (
    .clk      (clk),
    .rst      (rst),
    .pll_lock (pll_lock),
    .lock_s   (w_lock_s),
    .lock_lost(w_lock_lost)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PLL_RST;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      PLL_RST: begin
        if (r_timer == RST_LAST) w_next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_next_state = STABLE;
        end else if (r_timer == TIMEOUT_LAST) begin
          w_next_state = (r_retry_cnt == RETRY_MAX) ? FAULT : PLL_RST;
        end
      end
      STABLE: begin
        if (!w_lock_s) begin
          w_next_state = WAIT_LOCK;
        end else if (r_timer == STABLE_LAST) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (w_lock_lost) w_next_state = PLL_RST;
      end
      FAULT:   w_next_state = FAULT;
      default: w_next_state = PLL_RST;
    endcase
    if (restart) w_next_state = PLL_RST;
  end

  always_comb begin
    pll_resetb = !((r_state == PLL_RST) || (r_state == FAULT));
    core_rst   = (r_state != RUN);
    ready      = (r_state == RUN);
    fault      = (r_state == FAULT);
    state      = r_state;
  end

  // restart clears the timer even when already in PLL_RST, so the hold period restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer     <= '0;
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
    end else begin
      if (restart || (w_next_state != r_state)) begin
        r_timer <= '0;
      end else if ((r_state == PLL_RST) || (r_state == WAIT_LOCK) || (r_state == STABLE)) begin
        r_timer <= r_timer + 1'b1;
      end

      if (restart) begin
        r_retry_cnt <= '0;
      end else if ((r_state == WAIT_LOCK) && (w_next_state == PLL_RST)) begin
        r_retry_cnt <= r_retry_cnt + 2'd1;
      end else if ((r_state == STABLE) && (w_next_state == RUN)) begin
        r_retry_cnt <= '0;
      end

      if (!restart && (r_state == RUN) && w_lock_lost && (r_loss_cnt != '1)) begin
        r_loss_cnt <= r_loss_cnt + 1'b1;
      end
    end
  end

  assign retry_cnt = r_retry_cnt;
  assign loss_cnt  = r_loss_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: vector table for the main sequence and
// hand-written sequences for multi-cycle corner cases.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

`ifdef LOCK_GLITCH_FILTER_EN
  localparam int unsigned LOSS_LAT = 6;
`else
  localparam int unsigned LOSS_LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       restart;
  logic       pll_resetb;
  logic       core_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  pll_lock_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (3),
    .LOSS_W       (8),
    .GLITCH_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_resetb(pll_resetb),
    .core_rst  (core_rst),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lock;
    logic        rs;
    int unsigned n;
    logic [2:0]  st;
    logic        resetb;
    logic        crst;
    logic        rdy;
    logic        flt;
    logic [1:0]  retry;
    logic [7:0]  loss;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int unsigned bound, input string nm);
    int unsigned k = 0;
    while (state !== s && k < bound) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(state), 32'(s));
  endtask

  task automatic chk_all(input string nm, input logic [2:0] st, input logic rb, input logic cr,
                         input logic rd, input logic fl, input logic [1:0] rc, input logic [7:0] lc);
    chk({nm, ".state"}, 32'(state), 32'(st));
    chk({nm, ".pll_resetb"}, 32'(pll_resetb), 32'(rb));
    chk({nm, ".core_rst"}, 32'(core_rst), 32'(cr));
    chk({nm, ".ready"}, 32'(ready), 32'(rd));
    chk({nm, ".fault"}, 32'(fault), 32'(fl));
    chk({nm, ".retry_cnt"}, 32'(retry_cnt), 32'(rc));
    chk({nm, ".loss_cnt"}, 32'(loss_cnt), 32'(lc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // lock, restart, edges, state, pll_resetb, core_rst, ready, fault, retry, loss
    vecs[0]  = '{1'b0, 1'b0,  3, PLL_RST,   1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[1]  = '{1'b0, 1'b0,  1, WAIT_LOCK, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 10, WAIT_LOCK, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[3]  = '{1'b1, 1'b0,  2, WAIT_LOCK, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[4]  = '{1'b1, 1'b0,  1, STABLE,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[5]  = '{1'b1, 1'b0,  7, STABLE,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[6]  = '{1'b1, 1'b0,  1, RUN,       1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};
    vecs[7]  = '{1'b0, 1'b1,  1, PLL_RST,   1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[8]  = '{1'b0, 1'b0,  3, PLL_RST,   1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[9]  = '{1'b0, 1'b0,  1, WAIT_LOCK, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 31, WAIT_LOCK, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[11] = '{1'b0, 1'b0,  1, PLL_RST,   1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0};
    vecs[12] = '{1'b0, 1'b0,  4, WAIT_LOCK, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0};
    vecs[13] = '{1'b0, 1'b0, 32, PLL_RST,   1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0};
    vecs[14] = '{1'b0, 1'b0, 36, PLL_RST,   1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 8'd0};
    vecs[15] = '{1'b0, 1'b0, 35, WAIT_LOCK, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 8'd0};
    vecs[16] = '{1'b0, 1'b0,  1, FAULT,     1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'd0};
    vecs[17] = '{1'b0, 1'b0, 20, FAULT,     1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'd0};
    vecs[18] = '{1'b0, 1'b1,  1, PLL_RST,   1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};

    rst      = 1'b1;
    pll_lock = 1'b0;
    restart  = 1'b0;
    tick(2);
    chk_all("reset", PLL_RST, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    rst = 1'b0;

    // Lock-up sequence, retries to FAULT, and restart out of FAULT
    for (int i = 0; i < 19; i++) begin
      pll_lock = vecs[i].lock;
      restart  = vecs[i].rs;
      tick(vecs[i].n);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].resetb, vecs[i].crst,
              vecs[i].rdy, vecs[i].flt, vecs[i].retry, vecs[i].loss);
    end
    restart = 1'b0;

    // One timeout consumed, then lock arrives; 1-cycle dropout in STABLE
    begin
      int unsigned k = 0;
      while (!(state === 3'(PLL_RST) && retry_cnt === 2'd1) && k < 100) begin
        tick(1);
        k++;
      end
      chk("stable.pre_retry", 32'(retry_cnt), 32'd1);
    end
    pll_lock = 1'b1;
    wait_state(STABLE, 20, "stable.enter");
    tick(3);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    chk("stable.timer5", 32'(state), 32'(STABLE));
    tick(1);
    chk("stable.drop_state", 32'(state), 32'(WAIT_LOCK));
    chk("stable.drop_retry", 32'(retry_cnt), 32'd1);
    tick(1);
    chk("stable.relock", 32'(state), 32'(STABLE));
    tick(7);
    chk("stable.not_ready", 32'(ready), 32'd0);
    tick(1);
    chk_all("stable.run", RUN, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);

    // Lock loss in RUN and loss counter saturation
    pll_lock = 1'b0;
    tick(LOSS_LAT - 1);
    chk("loss.still_run", 32'(core_rst), 32'd0);
    tick(1);
    chk("loss.core_rst", 32'(core_rst), 32'd1);
    chk("loss.state", 32'(state), 32'(PLL_RST));
    chk("loss.cnt1", 32'(loss_cnt), 32'd1);
    for (int i = 2; i <= 301; i++) begin
      pll_lock = 1'b1;
      wait_state(RUN, 60, "loss.loop_run");
      pll_lock = 1'b0;
      wait_state(PLL_RST, 20, "loss.loop_rst");
      if (i == 200) chk("loss.cnt200", 32'(loss_cnt), 32'd200);
    end
    chk("loss.saturated", 32'(loss_cnt), 32'd255);

    // restart on the same edge as the final WAIT_LOCK timeout
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    begin
      int unsigned k = 0;
      while (!(state === 3'(WAIT_LOCK) && retry_cnt === 2'd3) && k < 200) begin
        tick(1);
        k++;
      end
      chk("race.last_wait", 32'(retry_cnt), 32'd3);
    end
    tick(31);
    chk("race.pre", 32'(state), 32'(WAIT_LOCK));
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk_all("race.post", PLL_RST, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd255);

    // rst mid-sequence, during STABLE
    pll_lock = 1'b1;
    wait_state(STABLE, 20, "rst.stable");
    tick(2);
    rst = 1'b1;
    tick(1);
    chk_all("rst.abort", PLL_RST, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    rst = 1'b0;

`ifdef LOCK_GLITCH_FILTER_EN
    wait_state(RUN, 60, "glitch.run");
    pll_lock = 1'b0;
    tick(3);
    pll_lock = 1'b1;
    tick(6);
    chk("glitch3.ready", 32'(ready), 32'd1);
    chk("glitch3.loss", 32'(loss_cnt), 32'd0);
    pll_lock = 1'b0;
    tick(4);
    pll_lock = 1'b1;
    tick(1);
    chk("glitch4.still_run", 32'(state), 32'(RUN));
    tick(1);
    chk("glitch4.state", 32'(state), 32'(PLL_RST));
    chk("glitch4.loss", 32'(loss_cnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
